// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage-buffer state encoding and the
// default payload/sideband widths used by the FD, DE, EM and MW stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_FULL,
    PS_SKID
  } pipe_state_t;

  // Default stage geometry: payload is {pc, instruction}, sideband is the INT flag.
  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_SB_W   = 1;

  localparam int FD_DATA_W = DEFAULT_DATA_W;
  localparam int FD_SB_W   = DEFAULT_SB_W;
  localparam int DE_DATA_W = DEFAULT_DATA_W;
  localparam int DE_SB_W   = DEFAULT_SB_W;
  localparam int EM_DATA_W = DEFAULT_DATA_W;
  localparam int EM_SB_W   = DEFAULT_SB_W;
  localparam int MW_DATA_W = DEFAULT_DATA_W;
  localparam int MW_SB_W   = DEFAULT_SB_W;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit plus payload and sideband, with load and
// clear controls. Clear wins over load so a flush can never be undone by a
// simultaneous capture. An empty entry always shows RST_VAL / zero sideband.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = DEFAULT_DATA_W,
  parameter int                SB_W    = DEFAULT_SB_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [SB_W-1:0]   d_sb,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [SB_W-1:0]   sb
);

  // Entry storage; stage state advances on the falling clock edge.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RST_VAL;
      sb    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= RST_VAL;
      sb    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      sb    <= d_sb;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and a sideband channel that travels with the payload.
// Build option PIPE_STAGE_BUF_SKID_EN: when defined, a second (skid) entry is
// added and o_ready comes straight from a flop; when undefined, a single entry
// is used and o_ready passes downstream ready through combinationally.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int                DATA_W  = DEFAULT_DATA_W,
  parameter int                SB_W    = DEFAULT_SB_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [SB_W-1:0]   i_sb,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [SB_W-1:0]   o_sb
);

  pipe_state_t       state;
  pipe_state_t       state_next;
  logic              in_xfer;
  logic              out_xfer;
  logic              head_load;
  logic              head_clear;
  logic [DATA_W-1:0] head_d_data;
  logic [SB_W-1:0]   head_d_sb;

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = o_valid & i_ready;

  // Occupancy state register.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= PS_EMPTY;
    end else begin
      state <= state_next;
    end
  end

`ifdef PIPE_STAGE_BUF_SKID_EN
  logic              skid_load;
  logic              skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [SB_W-1:0]   skid_sb;
  logic              ready_reg;

  // Next-state and entry controls; a stalled input while FULL parks in the skid slot.
  always_comb begin
    state_next = state;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      state_next = PS_EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_xfer) begin
            head_load  = 1'b1;
            state_next = PS_FULL;
          end
        end
        PS_FULL: begin
          if (in_xfer && out_xfer) begin
            head_load = 1'b1;
          end else if (in_xfer) begin
            skid_load  = 1'b1;
            state_next = PS_SKID;
          end else if (out_xfer) begin
            head_clear = 1'b1;
            state_next = PS_EMPTY;
          end
        end
        PS_SKID: begin
          if (out_xfer) begin
            head_load  = 1'b1;
            skid_clear = 1'b1;
            state_next = PS_FULL;
          end
        end
        default: begin
          state_next = PS_EMPTY;
        end
      endcase
    end
  end

  // The head refills from the skid slot whenever that slot is occupied.
  assign head_d_data = skid_valid ? skid_data : i_data;
  assign head_d_sb   = skid_valid ? skid_sb   : i_sb;

  pipe_entry_reg #(
    .DATA_W  (DATA_W),
    .SB_W    (SB_W),
    .RST_VAL (RST_VAL)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (skid_load),
    .clear  (skid_clear),
    .d_data (i_data),
    .d_sb   (i_sb),
    .valid  (skid_valid),
    .data   (skid_data),
    .sb     (skid_sb)
  );

  // Registered ready: low in reset, then high unless both entries are occupied.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= (state_next != PS_SKID);
    end
  end

  assign o_ready = ready_reg;
`else
  logic alive_reg;

  // Holds ready low through reset and for the first edge after release.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      alive_reg <= 1'b0;
    end else begin
      alive_reg <= 1'b1;
    end
  end

  assign o_ready = alive_reg & (~o_valid | i_ready);

  // Next-state and head controls for the single-entry stage.
  always_comb begin
    state_next = state;
    head_load  = 1'b0;
    head_clear = 1'b0;
    if (flush) begin
      state_next = PS_EMPTY;
      head_clear = 1'b1;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (in_xfer) begin
            head_load  = 1'b1;
            state_next = PS_FULL;
          end
        end
        PS_FULL: begin
          if (in_xfer) begin
            head_load = 1'b1;
          end else if (out_xfer) begin
            head_clear = 1'b1;
            state_next = PS_EMPTY;
          end
        end
        default: begin
          state_next = PS_EMPTY;
        end
      endcase
    end
  end

  assign head_d_data = i_data;
  assign head_d_sb   = i_sb;
`endif

  pipe_entry_reg #(
    .DATA_W  (DATA_W),
    .SB_W    (SB_W),
    .RST_VAL (RST_VAL)
  ) u_head (
    .clk    (clk),
    .rst    (rst),
    .load   (head_load),
    .clear  (head_clear),
    .d_data (head_d_data),
    .d_sb   (head_d_sb),
    .valid  (o_valid),
    .data   (o_data),
    .sb     (o_sb)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: directed steps followed by random traffic,
// checked against a queue-based model of the stage's occupancy.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] i_data;
  logic [0:0]  i_sb;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_data;
  logic [0:0]  o_sb;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] d;
    logic        sb;
  } ent_t;

  ent_t q[$];
  logic alive;

  pipe_stage_buf #(
    .DATA_W  (64),
    .SB_W    (1),
    .RST_VAL (64'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_sb    (i_sb),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sb    (o_sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ready as seen by upstream, from the model's occupancy.
  function automatic logic exp_ready();
`ifdef PIPE_STAGE_BUF_SKID_EN
    return alive && (q.size() < 2);
`else
    return alive && ((q.size() == 0) || i_ready);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] ed;
    logic        es;
    ed = (q.size() > 0) ? q[0].d : 64'h0;
    es = (q.size() > 0) ? q[0].sb : 1'b0;
    chk({tag, "_valid"}, 64'(o_valid), 64'(q.size() > 0));
    chk({tag, "_data"},  o_data, ed);
    chk({tag, "_sb"},    64'(o_sb), 64'(es));
    chk({tag, "_ready"}, 64'(o_ready), 64'(exp_ready()));
  endtask

  // One clock cycle: drive on the rising edge, check, let the stage update
  // on the falling edge, advance the model, check again.
  task automatic step(input logic v, input logic [63:0] d, input logic sb,
                      input logic rdy, input logic fl);
    logic in_x;
    logic out_x;
    @(posedge clk);
    i_valid = v;
    i_data  = d;
    i_sb    = sb;
    i_ready = rdy;
    flush   = fl;
    #1;
    check_all("pre");
    in_x  = v && exp_ready();
    out_x = (q.size() > 0) && rdy;
    @(negedge clk);
    if (!rst) begin
      if (out_x) $display("xfer out data=%h sb=%0d", q[0].d, q[0].sb);
      alive = 1'b1;
      if (fl) begin
        q.delete();
      end else begin
        if (out_x) void'(q.pop_front());
        if (in_x) q.push_back('{d: d, sb: sb});
      end
    end
    #1;
    check_all("post");
  endtask

  task automatic release_reset();
    @(posedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_ready_low", 64'(o_ready), 64'h0);
    @(negedge clk);
    #1;
    alive = 1'b1;
    chk("rst_ready_after_edge", 64'(o_ready), 64'h1);
  endtask

  initial begin
    rst     = 1'b1;
    flush   = 1'b0;
    i_valid = 1'b0;
    i_data  = 64'h0;
    i_sb    = 1'b0;
    i_ready = 1'b0;
    alive   = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    release_reset();

    // Back-to-back stream at full throughput.
    step(1'b1, 64'h1, 1'b0, 1'b1, 1'b0);
    chk("t2_d1", o_data, 64'h1);
    step(1'b1, 64'h2, 1'b0, 1'b1, 1'b0);
    chk("t2_d2", o_data, 64'h2);
    step(1'b1, 64'h3, 1'b0, 1'b1, 1'b0);
    chk("t2_d3", o_data, 64'h3);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("t2_drain", 64'(o_valid), 64'h0);

    // Asynchronous reset with a valid head.
    step(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);
    chk("t1_head", o_data, 64'hA);
    i_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t1_async_valid", 64'(o_valid), 64'h0);
    chk("t1_async_data", o_data, 64'h0);
    chk("t1_async_ready", 64'(o_ready), 64'h0);
    q.delete();
    alive = 1'b0;
    release_reset();

`ifdef PIPE_STAGE_BUF_SKID_EN
    // Stalled input lands in the skid slot, then both drain in order.
    step(1'b1, 64'h11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0, 1'b0);
    chk("t3_ready_low", 64'(o_ready), 64'h0);
    chk("t3_head_held", o_data, 64'h11);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("t3_second_out", o_data, 64'h22);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("t3_empty", 64'(o_valid), 64'h0);
`else
    // Combinational ready follows downstream ready while full.
    step(1'b1, 64'h33, 1'b0, 1'b1, 1'b0);
    i_valid = 1'b0;
    i_ready = 1'b0;
    #1;
    chk("t6_ready_low", 64'(o_ready), 64'h0);
    i_ready = 1'b1;
    #1;
    chk("t6_ready_high", 64'(o_ready), 64'h1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
`endif

    // Flush drops a simultaneous input.
    step(1'b1, 64'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h55, 1'b0, 1'b0, 1'b1);
    chk("t4_flush_valid", 64'(o_valid), 64'h0);
    chk("t4_flush_data", o_data, 64'h0);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    chk("t4_no_55", o_data, 64'h0);

    // Sideband and payload held through a 3-cycle stall.
    step(1'b1, 64'h77, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
      chk("t5_sb", 64'(o_sb), 64'h1);
      chk("t5_data", o_data, 64'h77);
    end
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 1) == 1), {$urandom(), $urandom()},
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
